dmem_port_arbiter: RTL
======================

Name: dmem_port_arbiter

Overview:
- Sequences and shares the single data-memory BRAM port between two requesters: the core load/store path (port 0, "c_") and the debug/program loader (port 1, "d_").
- Performs misalignment checking, byte-lane write steering, and 1-cycle synchronous-read return with lane extraction and sign extension.
- Sits between the MEM pipeline stage / loader and the external BRAM (douta latency = 1 clk).

Parameters:
- AW, 32, byte address width of requests
- DW, 32, data width (fixed 4 byte lanes)
- TW, 4, access-type width (`BYTE / `HALFWORD / `FULLWORD codes from GLOBALS.v)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- c_req / d_req  in  1  request valid
- c_we / d_we  in  1  1 = store, 0 = load
- c_type / d_type  in  TW  access size
- c_sign / d_sign  in  1  sign-extend load
- c_addr / d_addr  in  AW  byte address
- c_wdat / d_wdat  in  DW  store data, right-aligned
- c_gnt / d_gnt  out  1  request accepted this cycle
- c_err / d_err  out  1  misaligned, pulses with gnt
- c_rvalid / d_rvalid  out  1  load data valid
- c_rdata / d_rdata  out  DW  extended load data
- c_stall  out  1  c_req && !c_gnt
- bram_addr  out  AW  word address {2'b00, addr[AW-1:2]}
- wea  out  4  byte write enables
- dina  out  DW  lane-steered write data
- bram_read  in  DW  BRAM douta, valid 1 clk after address

Behaviour:
- Reset (rst=1 at posedge): all gnt, err, rvalid = 0; rdata = 0; wea = 0; in-flight register cleared; priority pointer = port 0.
- bram_addr, wea, and dina are combinational from the granted request.
- When nothing is granted: wea = 0, dina = 0, bram_addr = 0.
- Arbitration (combinational, each cycle): at most one gnt. Default is fixed priority, port 0 over port 1.
- A granted request is consumed; the requester must hold req and its fields stable until gnt.
- Misalignment: error when HALFWORD with addr[0] = 1, or FULLWORD with addr[1:0] != 0.
  - On a misaligned grant: err = 1 with gnt, wea = 0, no rvalid follows.
- Store, latency 0: the write occurs at the grant-cycle posedge.
  - FULLWORD: wea = 1111.
  - HALFWORD: wea = 0011 or 1100 by addr[1]; data placed in the selected half.
  - BYTE: wea = one-hot by addr[1:0]; data placed in that lane.
  - Non-enabled dina lanes = 0.
- Load, latency 1: the grant cycle presents the address. A 1-deep in-flight register captures {valid, owner, type, sign, addr[1:0]}.
  - Next cycle: owner's rvalid = 1 for exactly one cycle.
  - rdata is extracted from bram_read by lane: byte lane = addr[1:0], half lane = addr[1].
  - sign = 1 sign-extends the top bit of the extracted value; sign = 0 zero-extends. FULLWORD passes through.
  - Non-owner rvalid = 0. rdata is registered-free combinational from bram_read and in-flight; it is 0 when rvalid = 0.
- Back-to-back: a new grant is allowed in the same cycle a read returns (full throughput, one access per cycle).
- FSM (2 states):
  - IDLE → RD_PEND on an aligned load grant.
  - RD_PEND → RD_PEND on another aligned load grant.
  - RD_PEND → IDLE otherwise.
- Store following a load: permitted next cycle. Returned data reflects pre-store contents.
- Reset mid-read: the in-flight read is dropped; no rvalid after reset.
- Unknown type code: treated as misaligned (err = 1, no access).

Optional Feature:
- DMEM_RR_EN defined: round-robin arbitration.
  - On a cycle with both req = 1, the port not granted last is granted.
  - The pointer updates only on a contested grant and resets to port 0.
- DMEM_RR_EN undefined: fixed priority to port 0. Port 1 may starve while c_req is held.

Decomposition:
- GLOBALS.v: `BYTE / `HALFWORD / `FULLWORD codes, FSM state codes DMEM_IDLE / DMEM_RD_PEND, owner IDs DMEM_OWN_CORE = 0 / DMEM_OWN_DBG = 1.
- Sub-module dmem_lane_align: purely combinational.
  - Store side: wea/dina generation and misalignment flag.
  - Load side: lane extraction plus sign/zero extension.
  - Instantiated once for the write path and used by the read-return path.

Test Plan:
- Core SB 0xA5 to addr 0x102 → c_gnt = 1, wea = 0100, dina = 0x00A50000, bram_addr = 0x40.
- After a FULLWORD store of 0x80F17F01 to word 0x40: core LB sign = 1 at 0x101 → next cycle c_rvalid = 1, c_rdata = 0x0000007F. LB at 0x102 → 0xFFFFFFF1. LHU at 0x102 → 0x000080F1.
- Core LW at 0x103 → c_gnt = 1, c_err = 1, wea = 0, no c_rvalid next cycle.
- Both req held 4 cycles:
  - without DMEM_RR_EN, grants go c,c,c,c and c_stall = 0, with d_gnt = 0 throughout;
  - with DMEM_RR_EN, grants go c,d,c,d and d_rvalid tracks d loads.
- Back-to-back core loads at 0x100, 0x104, 0x108 → three consecutive gnt cycles, then rvalid on three consecutive cycles with correct data.
- Assert rst during the RD_PEND cycle → no rvalid afterwards; all outputs 0 during reset.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter_pkg
// Shared definitions for the data-memory port arbiter:
//   - access-type codes (BYTE / HALFWORD / FULLWORD)
//   - arbiter FSM state encoding
//   - in-flight read owner IDs
// -----------------------------------------------------------------------------
package dmem_port_arbiter_pkg;

   localparam int TYPE_W = 4;

   localparam logic [TYPE_W-1:0] BYTE     = 4'd0;
   localparam logic [TYPE_W-1:0] HALFWORD = 4'd1;
   localparam logic [TYPE_W-1:0] FULLWORD = 4'd2;

   typedef enum logic {
      DMEM_IDLE    = 1'b0,
      DMEM_RD_PEND = 1'b1
   } dmem_state_t;

   localparam logic DMEM_OWN_CORE = 1'b0;
   localparam logic DMEM_OWN_DBG  = 1'b1;

endpackage

// File: rtl/dmem_port_arbiter_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational byte-lane helper for a 32-bit, 4-lane memory word.
//   Store side: st_type/st_lane/st_wdat -> st_wea (byte enables), st_dina
//               (lane-steered data, disabled lanes zero), st_err (misaligned
//               or unknown type; st_wea is 0 whenever st_err is set).
//   Load side:  ld_type/ld_sign/ld_lane/ld_word -> ld_data (extracted lane,
//               sign- or zero-extended; FULLWORD passes through).
// -----------------------------------------------------------------------------
module dmem_lane_align
   import dmem_port_arbiter_pkg::*;
#(
   parameter int TW = 4
) (
   input  logic [TW-1:0] st_type,
   input  logic [1:0]    st_lane,
   input  logic [31:0]   st_wdat,
   output logic [3:0]    st_wea,
   output logic [31:0]   st_dina,
   output logic          st_err,
   input  logic [TW-1:0] ld_type,
   input  logic          ld_sign,
   input  logic [1:0]    ld_lane,
   input  logic [31:0]   ld_word,
   output logic [31:0]   ld_data
);

   logic [31:0] st_rep;
   logic [31:0] ld_shift;
   logic [15:0] ld_half;

   // Store side: replicate the right-aligned data into every candidate lane,
   // then let the byte enables decide which lanes survive.
   always_comb begin
      st_wea = 4'b0000;
      st_err = 1'b0;
      st_rep = st_wdat;
      case (st_type)
         TW'(BYTE): begin
            st_wea = 4'b0001 << st_lane;
            st_rep = {4{st_wdat[7:0]}};
         end
         TW'(HALFWORD): begin
            st_rep = {2{st_wdat[15:0]}};
            if (st_lane[0]) st_err = 1'b1;
            else            st_wea = st_lane[1] ? 4'b1100 : 4'b0011;
         end
         TW'(FULLWORD): begin
            if (st_lane != 2'b00) st_err = 1'b1;
            else                  st_wea = 4'b1111;
         end
         default: st_err = 1'b1;
      endcase
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign st_dina[gi*8 +: 8] = st_wea[gi] ? st_rep[gi*8 +: 8] : 8'h00;
   end

   // Load side
   always_comb begin
      ld_shift = ld_word >> {ld_lane, 3'b000};
      ld_half  = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
      case (ld_type)
         TW'(BYTE):     ld_data = {{24{ld_sign & ld_shift[7]}}, ld_shift[7:0]};
         TW'(HALFWORD): ld_data = {{16{ld_sign & ld_half[15]}}, ld_half};
         default:       ld_data = ld_word;
      endcase
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
// Shares one data-memory BRAM port (1-cycle read latency) between the core
// load/store path (port 0, c_*) and the debug/program loader (port 1, d_*).
//   c_/d_ req, we, type, sign, addr, wdat : request inputs (held until gnt)
//   c_/d_ gnt, err                         : grant / misaligned flag (same cycle)
//   c_/d_ rvalid, rdata                    : load return, one cycle after grant
//   c_stall                                : core request waiting this cycle
//   bram_addr, wea, dina                   : combinational BRAM drive
//   bram_read                              : BRAM douta
// Build option: DMEM_RR_EN selects round-robin on contested cycles; otherwise
// port 0 has fixed priority.
// -----------------------------------------------------------------------------
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int TW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [TW-1:0] c_type,
   input  logic          c_sign,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdat,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [TW-1:0] d_type,
   input  logic          d_sign,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdat,
   output logic          c_gnt,
   output logic          c_err,
   output logic          c_rvalid,
   output logic [DW-1:0] c_rdata,
   output logic          d_gnt,
   output logic          d_err,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          c_stall,
   output logic [AW-1:0] bram_addr,
   output logic [3:0]    wea,
   output logic [DW-1:0] dina,
   input  logic [DW-1:0] bram_read
);

   dmem_state_t   state_reg, state_next;
   logic          owner_reg;
   logic [TW-1:0] type_reg;
   logic          sign_reg;
   logic [1:0]    lane_reg;

   logic          pick_d;
   logic          gnt_any;
   logic          sel_we;
   logic [TW-1:0] sel_type;
   logic          sel_sign;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdat;
   logic [3:0]    st_wea;
   logic [DW-1:0] st_dina;
   logic          st_err;
   logic [DW-1:0] ld_data;
   logic          wr_ok;
   logic          rd_start;
   logic          rd_ret;

`ifdef DMEM_RR_EN
   // Port preferred on the next contested cycle; flips after each contested grant.
   logic prio_reg;

   always_ff @(posedge clk) begin
      if (rst)                       prio_reg <= 1'b0;
      else if (c_req && d_req)       prio_reg <= ~prio_reg;
   end

   assign pick_d = (c_req && d_req) ? prio_reg : d_req;
`else
   assign pick_d = !c_req && d_req;
`endif

   // Nothing is granted while reset is asserted, so every BRAM drive is quiet.
   assign c_gnt   = c_req && !pick_d && !rst;
   assign d_gnt   = d_req &&  pick_d && !rst;
   assign gnt_any = c_gnt || d_gnt;
   assign c_stall = c_req && !c_gnt && !rst;

   assign sel_we   = d_gnt ? d_we   : c_we;
   assign sel_type = d_gnt ? d_type : c_type;
   assign sel_sign = d_gnt ? d_sign : c_sign;
   assign sel_addr = d_gnt ? d_addr : c_addr;
   assign sel_wdat = d_gnt ? d_wdat : c_wdat;

   dmem_lane_align #(.TW(TW)) u_align (
      .st_type (sel_type),
      .st_lane (sel_addr[1:0]),
      .st_wdat (sel_wdat),
      .st_wea  (st_wea),
      .st_dina (st_dina),
      .st_err  (st_err),
      .ld_type (type_reg),
      .ld_sign (sign_reg),
      .ld_lane (lane_reg),
      .ld_word (bram_read),
      .ld_data (ld_data)
   );

   assign c_err    = c_gnt && st_err;
   assign d_err    = d_gnt && st_err;
   assign wr_ok    = gnt_any &&  sel_we && !st_err;
   assign rd_start = gnt_any && !sel_we && !st_err;

   assign wea       = wr_ok   ? st_wea  : 4'b0000;
   assign dina      = wr_ok   ? st_dina : '0;
   assign bram_addr = gnt_any ? {2'b00, sel_addr[AW-1:2]} : '0;

   // FSM: RD_PEND marks that the BRAM output this cycle belongs to a load.
   always_ff @(posedge clk) begin
      if (rst) state_reg <= DMEM_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = DMEM_IDLE;
      case (state_reg)
         DMEM_IDLE:    if (rd_start) state_next = DMEM_RD_PEND;
         DMEM_RD_PEND: if (rd_start) state_next = DMEM_RD_PEND;
         default:      state_next = DMEM_IDLE;
      endcase
   end

   // In-flight descriptor, captured only when a load is issued.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_reg <= DMEM_OWN_CORE;
         type_reg  <= '0;
         sign_reg  <= 1'b0;
         lane_reg  <= 2'b00;
      end else if (rd_start) begin
         owner_reg <= d_gnt ? DMEM_OWN_DBG : DMEM_OWN_CORE;
         type_reg  <= sel_type;
         sign_reg  <= sel_sign;
         lane_reg  <= sel_addr[1:0];
      end
   end

   // A read pending when reset rises is dropped, including the reset cycle.
   assign rd_ret   = (state_reg == DMEM_RD_PEND) && !rst;
   assign c_rvalid = rd_ret && (owner_reg == DMEM_OWN_CORE);
   assign d_rvalid = rd_ret && (owner_reg == DMEM_OWN_DBG);
   assign c_rdata  = c_rvalid ? ld_data : '0;
   assign d_rdata  = d_rvalid ? ld_data : '0;

endmodule
